prbs65_16_chk: RTL and testbench

Self-synchronizing checker for the 16-bit words produced by the 65-bit PRBS generator (x^65 + x^18 + 1, one-bit shift per word). It sits directly downstream of the generator, at the receive end of a link under test. It recovers the full 65-bit generator state from the incoming data, then locks and compares every valid word against a local LFSR copy. It counts bit and word errors and reports loss of lock for the radiation/link test firmware.

---
 rtl/prbs65_16_chk.sv | 151 +++++++++++++++
 tb/tb_prbs65_16_chk.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/prbs65_16_chk.sv
// Self-synchronizing checker for the 16-bit x^65+x^18+1 PRBS stream.
// Recovers generator state from data, then checks against a free-running copy.
module prbs65_16_chk #(
  parameter int LOS_THRESH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] din,
  input  logic        din_vld,
  input  logic        clear_cnt,
  output logic        locked,
  output logic        word_err,
  output logic        lock_lost,
  output logic [31:0] bit_err_cnt,
  output logic [15:0] word_err_cnt,
  output logic [31:0] word_cnt
);

  typedef enum logic {SYNC, LOCK} st_t;

  localparam logic [3:0] LT = 4'(LOS_THRESH);

  function automatic logic [64:0] step(input logic [64:0] s);
    return {s[63:0], s[64] ^ s[17]};
  endfunction

  st_t         r_state, w_next;
  logic [64:0] r_cap, r_lfsr;
  logic [15:0] r_prev;
  logic [5:0]  r_fill;
  logic [3:0]  r_consec;
  logic        r_word_err, r_lock_lost;
  logic [31:0] r_bit_cnt, r_word_cnt;
  logic [15:0] r_werr_cnt;

  logic [15:0] w_diff;
  logic [4:0]  w_pop;
  logic        w_cons;
  logic [5:0]  w_fill_nx;
  logic [64:0] w_full;
  logic        w_done, w_zero, w_err, w_los;
  logic [3:0]  w_consec_nx;
  logic [32:0] w_bsum;

  always_comb begin
    w_diff = din ^ r_lfsr[15:0];
    w_pop  = '0;
    for (int i = 0; i < 16; i++)
      w_pop = w_pop + 5'(w_diff[i]);
  end

  // A word must continue the previous one shifted by one bit.
  assign w_cons      = (r_fill == 6'd0) || (din[15:1] == r_prev[14:0]);
  assign w_fill_nx   = w_cons ? r_fill + 6'd1 : 6'd1;
  assign w_full      = {r_cap[63:15], din};
  assign w_zero      = (w_full == 65'd0);
  assign w_done      = din_vld && (r_state == SYNC)
                       && (w_fill_nx == 6'd50);
  assign w_err       = din_vld && (r_state == LOCK)
                       && (w_pop != 5'd0);
  assign w_consec_nx = r_consec + 4'd1;
  assign w_los       = w_err && (w_consec_nx == LT);
  assign w_bsum      = {1'b0, r_bit_cnt} + 33'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SYNC;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      SYNC: if (w_done && !w_zero) w_next = LOCK;
      LOCK: if (w_los) w_next = SYNC;
      default: w_next = SYNC;
    endcase
  end

  always_comb begin
    locked = (r_state == LOCK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap    <= '0;
      r_prev   <= '0;
      r_lfsr   <= '0;
      r_fill   <= '0;
      r_consec <= '0;
    end else if (din_vld) begin
      if (r_state == SYNC) begin
        r_cap  <= w_full;
        r_prev <= din;
        if (w_fill_nx == 6'd50) begin
          r_fill <= '0;
          if (!w_zero) begin
            r_lfsr   <= step(w_full);
            r_consec <= '0;
          end
        end else begin
          r_fill <= w_fill_nx;
        end
      end else begin
        r_lfsr <= step(r_lfsr);
        if (w_los) begin
          r_fill   <= '0;
          r_consec <= '0;
        end else if (w_err) begin
          r_consec <= w_consec_nx;
        end else begin
          r_consec <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_err  <= 1'b0;
      r_lock_lost <= 1'b0;
      r_bit_cnt   <= '0;
      r_werr_cnt  <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_word_err <= w_err;
      if (clear_cnt) begin
        r_lock_lost <= 1'b0;
        r_bit_cnt   <= '0;
        r_werr_cnt  <= '0;
        r_word_cnt  <= '0;
      end else if (din_vld && r_state == LOCK) begin
        if (r_word_cnt != '1)
          r_word_cnt <= r_word_cnt + 32'd1;
        if (w_err) begin
          if (r_werr_cnt != '1)
            r_werr_cnt <= r_werr_cnt + 16'd1;
          r_bit_cnt <= w_bsum[32] ? '1 : w_bsum[31:0];
        end
        if (w_los)
          r_lock_lost <= 1'b1;
      end
    end
  end

  assign word_err     = r_word_err;
  assign lock_lost    = r_lock_lost;
  assign bit_err_cnt  = r_bit_cnt;
  assign word_err_cnt = r_werr_cnt;
  assign word_cnt     = r_word_cnt;

endmodule

// File: tb/tb_prbs65_16_chk.sv
// Bench for prbs65_16_chk: table vectors plus multi-cycle sequences,
// with a queue of expected word_err/locked values per driven cycle.
module tb_prbs65_16_chk;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din;
  logic        din_vld;
  logic        clear_cnt;
  logic        locked;
  logic        word_err;
  logic        lock_lost;
  logic [31:0] bit_err_cnt;
  logic [15:0] word_err_cnt;
  logic [31:0] word_cnt;

  int total = 0;
  int bad = 0;

  prbs65_16_chk #(.LOS_THRESH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .din_vld      (din_vld),
    .clear_cnt    (clear_cnt),
    .locked       (locked),
    .word_err     (word_err),
    .lock_lost    (lock_lost),
    .bit_err_cnt  (bit_err_cnt),
    .word_err_cnt (word_err_cnt),
    .word_cnt     (word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] msk;
    logic        vld;
    logic        clr;
    logic        e;
    logic        l;
  } vec_t;

  typedef struct {
    logic e;
    logic l;
  } exp_t;

  exp_t        sb[$];
  logic [64:0] g;

  function automatic logic [64:0] gstep(input logic [64:0] s);
    return {s[63:0], s[64] ^ s[17]};
  endfunction

  task automatic gen(output logic [15:0] w);
    w = g[15:0];
    g = gstep(g);
  endtask

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic v,
                      input logic c, input logic e, input logic l);
    exp_t x;
    din       = d;
    din_vld   = v;
    clear_cnt = c;
    sb.push_back('{e: e, l: l});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("word_err", 32'(word_err), 32'(x.e));
    chk("locked", 32'(locked), 32'(x.l));
    din_vld   = 1'b0;
    clear_cnt = 1'b0;
  endtask

  task automatic cnts(input string n, input logic [31:0] be,
                      input logic [31:0] we, input logic [31:0] wc);
    chk({n, ".bit_err_cnt"}, bit_err_cnt, be);
    chk({n, ".word_err_cnt"}, 32'(word_err_cnt), we);
    chk({n, ".word_cnt"}, word_cnt, wc);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst.locked", 32'(locked), 0);
    chk("rst.word_err", 32'(word_err), 0);
    chk("rst.lock_lost", 32'(lock_lost), 0);
    cnts("rst", 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic lock50();
    logic [15:0] w;
    for (int k = 1; k <= 50; k++) begin
      gen(w);
      send(w, 1'b1, 1'b0, 1'b0, k == 50);
    end
  endtask

  vec_t tab[9];

  initial begin
    logic [15:0] w;
    int nv, it;
    tab[0] = '{16'h0000, 1, 0, 0, 1};
    tab[1] = '{16'h0081, 1, 0, 1, 1};
    tab[2] = '{16'h0000, 1, 0, 0, 1};
    tab[3] = '{16'h0000, 0, 1, 0, 1};
    tab[4] = '{16'hFFFF, 1, 0, 1, 1};
    tab[5] = '{16'h0001, 1, 0, 1, 1};
    tab[6] = '{16'h0000, 0, 0, 0, 1};
    tab[7] = '{16'h0002, 1, 0, 1, 1};
    tab[8] = '{16'h0004, 1, 0, 1, 0};

    g         = 65'h1_2345_6789_ABCD_EF01;
    rst_n     = 1'b0;
    din       = '0;
    din_vld   = 1'b0;
    clear_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init.locked", 32'(locked), 0);
    chk("init.word_err", 32'(word_err), 0);
    chk("init.lock_lost", 32'(lock_lost), 0);
    cnts("init", 0, 0, 0);
    rst_n = 1'b1;

    // clean lock and long clean run
    lock50();
    for (int k = 0; k < 10000; k++) begin
      gen(w);
      send(w, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    cnts("clean", 0, 0, 10000);

    // two-bit error, then clear and four errored words
    for (int i = 0; i < 3; i++) begin
      if (tab[i].vld) gen(w);
      send(w ^ tab[i].msk, tab[i].vld, tab[i].clr, tab[i].e, tab[i].l);
    end
    cnts("flip2", 2, 1, 10003);
    chk("flip2.lock_lost", 32'(lock_lost), 0);
    for (int i = 3; i < 9; i++) begin
      if (tab[i].vld) gen(w);
      send(w ^ tab[i].msk, tab[i].vld, tab[i].clr, tab[i].e, tab[i].l);
    end
    cnts("los", 19, 4, 4);
    chk("los.lock_lost", 32'(lock_lost), 1);
    lock50();
    chk("relock.lock_lost", 32'(lock_lost), 1);

    // broken overlap at SYNC word 30 restarts the run
    do_reset();
    for (int k = 1; k <= 29; k++) begin
      gen(w);
      send(w, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    repeat (20) g = gstep(g);
    lock50();
    for (int k = 0; k < 5; k++) begin
      gen(w);
      send(w, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    cnts("resync", 0, 0, 5);

    // all-zero stream never locks
    do_reset();
    for (int k = 0; k < 60; k++)
      send(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    cnts("zero", 0, 0, 0);

    // clear coinciding with an errored word
    lock50();
    gen(w);
    send(w ^ 16'h0100, 1'b1, 1'b1, 1'b1, 1'b1);
    cnts("clrerr", 0, 0, 0);
    gen(w);
    send(w, 1'b1, 1'b0, 1'b0, 1'b1);
    cnts("clrnext", 0, 0, 1);

    // gapped valid while locked
    nv = 0;
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        gen(w);
        nv++;
        send(w, 1'b1, 1'b0, 1'b0, 1'b1);
      end else begin
        send(16'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
      end
    end
    cnts("gap", 0, 0, 32'(1 + nv));

    // async reset mid-lock, re-lock with gapped valid
    do_reset();
    nv = 0;
    it = 0;
    while (nv < 50 && it < 1000) begin
      it++;
      if ($urandom_range(0, 1) == 1) begin
        gen(w);
        nv++;
        send(w, 1'b1, 1'b0, 1'b0, nv == 50);
      end else begin
        send(16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    chk("gaplock.words", 32'(nv), 50);
    for (int k = 0; k < 5; k++) begin
      gen(w);
      send(w, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    cnts("gaplock", 0, 0, 5);
    chk("gaplock.lock_lost", 32'(lock_lost), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
